console_palette: RTL and testbench
==================================

Name: console_palette

Overview:
- Pipelined, programmable successor to the fixed text-mode attribute decoder. It sits between the console character/font fetch and the HDMI pixel path.
- Per pixel, it converts an 8-bit text attribute plus a font glyph bit into one RGB value.
- Colours come from a 16-entry palette RAM that is writable at run time and resets to the standard VGA colours.
- Adds frame-counted blink timing and a selectable blink / bright-background mode for attribute bit 7.

Parameters:
- CH_BITS, 8: bits per colour channel; legal range 4..8; rgb width is 3*CH_BITS.
- BLINK_FRAMES, 16: frame_start pulses per blink half-period; legal range 1..255.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pix_valid_in  in  1  attribute/glyph_pixel are valid this cycle
- attribute  in  8  [7]=blink/bright-bg, [6:4]=bg index, [3:0]=fg index
- glyph_pixel  in  1  font bit; 1 selects foreground, 0 selects background
- frame_start  in  1  one-cycle pulse per frame (vsync edge)
- blink_mode  in  1  1: attr[7] means blink; 0: attr[7] is bg index bit 3
- pal_we  in  1  palette write strobe
- pal_addr  in  4  palette entry to write
- pal_wdata  in  3*CH_BITS  {R,G,B} write data
- pix_valid_out  out  1  rgb_out is valid
- rgb_out  out  3*CH_BITS  {R,G,B} pixel colour
- blink_phase  out  1  current blink phase; 1 means blinking glyphs are hidden

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values:
  - pix_valid_out=0, rgb_out=0, blink_phase=0, frame counter=0, both pipeline stages cleared.
  - All 16 palette entries reloaded with the VGA defaults.
  - Default entries, index 0..F, in 8-bit-per-channel hex: 000000, 0000AA, 00AA00, 00AAAA, AA0000, AA00AA, AA5500, AAAAAA, 555555, 5555FF, 55FF55, 55FFFF, FF5555, FF55FF, FFFF55, FFFFFF.
  - Each 8-bit channel is right-shifted by (8-CH_BITS).
- Reset mid-operation: in-flight pixels are dropped (no pix_valid_out for them). Palette contents written before the reset are lost.
- Pipeline: fixed latency of 2 cycles, fully pipelined, one pixel per clock, no stall.
  - Stage 1 registers: pix_valid_in, attribute, glyph_pixel, blink_mode, and the current blink_phase. Blink state and mode are therefore fixed per pixel at capture time.
  - Stage 2 performs the palette lookup and registers pix_valid_out and rgb_out.
- Index selection (stage 2):
  - fg_idx = attr[3:0].
  - bg_idx = blink_mode ? {1'b0, attr[6:4]} : attr[7:4].
  - hide = blink_mode & attr[7] & captured blink_phase.
  - Colour = palette[(glyph_pixel & ~hide) ? fg_idx : bg_idx].
- Invalid cycles: when the stage-2 valid is 0, rgb_out is driven to 0.
- Palette write:
  - When pal_we=1 at edge N, entry pal_addr takes pal_wdata at edge N.
  - A stage-2 lookup registered at edge N+1 or later sees the new value.
  - A lookup of the same entry registered at edge N itself returns the old value (read-before-write).
  - Writes to other entries never disturb lookups.
  - pal_we during reset is ignored.
- Blink timer:
  - The frame counter increments on each frame_start.
  - On a frame_start while counter == BLINK_FRAMES-1: counter wraps to 0 and blink_phase toggles.
  - Blink_phase half-period is therefore BLINK_FRAMES frames; with BLINK_FRAMES=1 it toggles on every frame_start.
  - The timer runs regardless of blink_mode and pix_valid_in.
  - frame_start held high for k cycles counts as k events; sources must pulse it for one cycle.
- Simultaneous events:
  - A frame_start coinciding with a valid pixel: that pixel uses the pre-toggle blink_phase.
  - A palette write coinciding with a valid pixel follows the write-timing rules above.

Test Plan:
- Reset, then CH_BITS=8, blink_mode=1, pixels attr=0x1E with glyph_pixel=1 then 0 on consecutive cycles -> 2 cycles later rgb_out=FFFF55, then 0000AA; pix_valid_out high exactly 2 cycles.
- blink_mode=0, attr=0xC2, glyph_pixel=0 -> rgb_out=FF5555 (bg index C). Same pixel with blink_mode=1 -> AA0000 (bg index 4).
- BLINK_FRAMES=2, blink_mode=1, attr=0x8F, glyph_pixel=1 held:
  - blink_phase toggles after the 2nd, 4th and 6th frame_start pulses.
  - rgb_out alternates FFFFFF (phase 0) / 000000 (phase 1).
  - A pixel captured in the same cycle as the toggling pulse shows the old phase.
- Write pal_addr=3, pal_wdata=123456, while streaming attr=0x03 glyph=1 every cycle -> pixel registered at the write edge shows 00AAAA; all later pixels show 123456. Entry 5 still reads AA00AA.
- Write entry 0 = FFFFFF, assert reset for 1 cycle, then attr=0x00 glyph=0 -> rgb_out=000000. pix_valid_out=0 and blink_phase=0 in the cycle after reset.
- CH_BITS=4, attr=0x09 glyph=1 -> rgb_out=12'h55F. pix_valid_in low for 3 cycles -> rgb_out=0 and pix_valid_out=0 over the matching 3 output cycles.

Source files
------------

// File: rtl/console_palette.sv
// -----------------------------------------------------------------------------
// console_palette
//   Text-mode attribute to RGB converter with a run-time programmable 16-entry
//   palette and frame-counted blink timing. Two-stage pipeline, one pixel per
//   clock, fixed latency, no stall.
//
// Ports
//   clk            pixel clock
//   reset          synchronous, active-high reset
//   pix_valid_in   attribute / glyph_pixel valid this cycle
//   attribute      [7] blink or bright-bg, [6:4] bg index, [3:0] fg index
//   glyph_pixel    font bit; 1 = foreground, 0 = background
//   frame_start    one-cycle pulse per frame
//   blink_mode     1: attribute[7] means blink; 0: attribute[7] is bg bit 3
//   pal_we         palette write strobe
//   pal_addr       palette entry to write
//   pal_wdata      {R,G,B} write data
//   pix_valid_out  rgb_out valid
//   rgb_out        {R,G,B} pixel colour (zero when not valid)
//   blink_phase    1 while blinking glyphs are hidden
// -----------------------------------------------------------------------------
module console_palette #(
    parameter int CH_BITS      = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_valid_in,
    input  logic [7:0]             attribute,
    input  logic                   glyph_pixel,
    input  logic                   frame_start,
    input  logic                   blink_mode,
    input  logic                   pal_we,
    input  logic [3:0]             pal_addr,
    input  logic [3*CH_BITS-1:0]   pal_wdata,
    output logic                   pix_valid_out,
    output logic [3*CH_BITS-1:0]   rgb_out,
    output logic                   blink_phase
);

    localparam int         RGB_W      = 3 * CH_BITS;
    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    // Standard VGA text colours at 8 bits per channel.
    function automatic logic [23:0] vga_default(input logic [3:0] idx);
        logic [23:0] c;
        case (idx)
            4'h0:    c = 24'h000000;
            4'h1:    c = 24'h0000AA;
            4'h2:    c = 24'h00AA00;
            4'h3:    c = 24'h00AAAA;
            4'h4:    c = 24'hAA0000;
            4'h5:    c = 24'hAA00AA;
            4'h6:    c = 24'hAA5500;
            4'h7:    c = 24'hAAAAAA;
            4'h8:    c = 24'h555555;
            4'h9:    c = 24'h5555FF;
            4'hA:    c = 24'h55FF55;
            4'hB:    c = 24'h55FFFF;
            4'hC:    c = 24'hFF5555;
            4'hD:    c = 24'hFF55FF;
            4'hE:    c = 24'hFFFF55;
            4'hF:    c = 24'hFFFFFF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Right-shifting an 8-bit channel by (8-CH_BITS) keeps its top CH_BITS bits.
    function automatic logic [RGB_W-1:0] scale_colour(input logic [23:0] c);
        return {c[23 -: CH_BITS], c[15 -: CH_BITS], c[7 -: CH_BITS]};
    endfunction

    logic [RGB_W-1:0] pal_r [16];
    logic [7:0]       frame_cnt_r;
    logic             blink_phase_r;

    logic             valid1_r;
    logic [7:0]       attr1_r;
    logic             glyph1_r;
    logic             mode1_r;
    logic             phase1_r;

    logic             valid2_r;
    logic [RGB_W-1:0] rgb2_r;

    logic             hide_s;
    logic [3:0]       bg_idx_s;
    logic [3:0]       sel_idx_s;

    // Palette storage: VGA defaults on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                pal_r[i] <= scale_colour(vga_default(4'(i)));
            end
        end else if (pal_we) begin
            pal_r[pal_addr] <= pal_wdata;
        end
    end

    // Blink timer: counts frame_start pulses, toggles phase on wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r   <= 8'd0;
            blink_phase_r <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_r == LAST_FRAME) begin
                frame_cnt_r   <= 8'd0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + 8'd1;
            end
        end
    end

    // Stage 1: capture pixel together with the blink phase/mode in force now,
    // so a coincident frame_start only affects later pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_r <= 1'b0;
            attr1_r  <= 8'd0;
            glyph1_r <= 1'b0;
            mode1_r  <= 1'b0;
            phase1_r <= 1'b0;
        end else begin
            valid1_r <= pix_valid_in;
            attr1_r  <= attribute;
            glyph1_r <= glyph_pixel;
            mode1_r  <= blink_mode;
            phase1_r <= blink_phase_r;
        end
    end

    // Stage 2 index selection: hidden blinking glyphs fall back to background.
    always_comb begin
        hide_s    = 1'b0;
        bg_idx_s  = 4'd0;
        sel_idx_s = 4'd0;
        hide_s    = mode1_r & attr1_r[7] & phase1_r;
        if (mode1_r) begin
            bg_idx_s = {1'b0, attr1_r[6:4]};
        end else begin
            bg_idx_s = attr1_r[7:4];
        end
        if (glyph1_r & ~hide_s) begin
            sel_idx_s = attr1_r[3:0];
        end else begin
            sel_idx_s = bg_idx_s;
        end
    end

    // Stage 2: palette lookup. Reading pal_r on the same edge as a write
    // returns the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid2_r <= 1'b0;
            rgb2_r   <= {RGB_W{1'b0}};
        end else begin
            valid2_r <= valid1_r;
            rgb2_r   <= valid1_r ? pal_r[sel_idx_s] : {RGB_W{1'b0}};
        end
    end

    assign pix_valid_out = valid2_r;
    assign rgb_out       = rgb2_r;
    assign blink_phase   = blink_phase_r;

endmodule

// File: tb/tb_console_palette.sv
// -----------------------------------------------------------------------------
// tb_console_palette
//   Two instances share all stimulus: dut8 (CH_BITS=8, BLINK_FRAMES=2) and
//   dut4 (CH_BITS=4, BLINK_FRAMES=1). A cycle-level reference model derived
//   from the behavioural rules predicts every output on every edge; directed
//   scenarios additionally compare against literal colours.
// -----------------------------------------------------------------------------
module tb_console_palette;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid_in;
    logic [7:0]  attribute;
    logic        glyph_pixel;
    logic        frame_start;
    logic        blink_mode;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] wdata8;
    logic [11:0] wdata4;

    logic        valid8, phase8, valid4, phase4;
    logic [23:0] rgb8;
    logic [11:0] rgb4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    console_palette #(.CH_BITS(8), .BLINK_FRAMES(2)) dut8 (
        .clk(clk), .reset(reset), .pix_valid_in(pix_valid_in),
        .attribute(attribute), .glyph_pixel(glyph_pixel),
        .frame_start(frame_start), .blink_mode(blink_mode),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(wdata8),
        .pix_valid_out(valid8), .rgb_out(rgb8), .blink_phase(phase8)
    );

    console_palette #(.CH_BITS(4), .BLINK_FRAMES(1)) dut4 (
        .clk(clk), .reset(reset), .pix_valid_in(pix_valid_in),
        .attribute(attribute), .glyph_pixel(glyph_pixel),
        .frame_start(frame_start), .blink_mode(blink_mode),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(wdata4),
        .pix_valid_out(valid4), .rgb_out(rgb4), .blink_phase(phase4)
    );

    // ---------------- reference model ----------------
    logic [23:0] vga [16];
    logic [23:0] mpal8 [16];
    logic [11:0] mpal4 [16];
    int          bf   [2];
    int          cnt  [2];
    bit          ph   [2];
    bit          pv   [2];
    logic [7:0]  pa   [2];
    bit          pg   [2];
    bit          pm   [2];
    bit          pp   [2];
    bit          ev   [2];
    logic [23:0] er   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pick_index(input logic [7:0] a, input bit g, input bit m, input bit phase);
        bit hide;
        hide = m && a[7] && phase;
        if (g && !hide) return a[3:0];
        return m ? {1'b0, a[6:4]} : a[7:4];
    endfunction

    task automatic model_reset_palette();
        for (int i = 0; i < 16; i++) begin
            mpal8[i] = vga[i];
            mpal4[i] = {vga[i][23:20], vga[i][15:12], vga[i][7:4]};
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                ev[d] = 1'b0; er[d] = 24'h0; cnt[d] = 0; ph[d] = 1'b0; pv[d] = 1'b0;
            end else begin
                ev[d] = pv[d];
                if (pv[d]) begin
                    if (d == 0) er[d] = mpal8[pick_index(pa[d], pg[d], pm[d], pp[d])];
                    else        er[d] = {12'h0, mpal4[pick_index(pa[d], pg[d], pm[d], pp[d])]};
                end else begin
                    er[d] = 24'h0;
                end
                pv[d] = pix_valid_in; pa[d] = attribute; pg[d] = glyph_pixel;
                pm[d] = blink_mode;   pp[d] = ph[d];
                if (frame_start) begin
                    cnt[d]++;
                    if (cnt[d] == bf[d]) begin
                        cnt[d] = 0;
                        ph[d]  = !ph[d];
                    end
                end
            end
        end
        if (reset) begin
            model_reset_palette();
        end else if (pal_we) begin
            mpal8[pal_addr] = wdata8;
            mpal4[pal_addr] = wdata4;
        end
    endtask

    // One clock: edge, model update, sample #1 later, compare, back to negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("valid8", valid8, ev[0]);
        check_eq("rgb8",   rgb8,   er[0]);
        check_eq("phase8", phase8, ph[0]);
        check_eq("valid4", valid4, ev[1]);
        check_eq("rgb4",   rgb4,   er[1][11:0]);
        check_eq("phase4", phase4, ph[1]);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [7:0] a, input bit g, input bit m);
        pix_valid_in = v; attribute = a; glyph_pixel = g; blink_mode = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        vga = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
        bf[0] = 2; bf[1] = 1;
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; ph[d] = 0; pv[d] = 0; pa[d] = 8'h0; pg[d] = 0; pm[d] = 0; pp[d] = 0;
        end
        model_reset_palette();
        reset = 1'b1; frame_start = 1'b0; pal_we = 1'b0; pal_addr = 4'h0;
        wdata8 = 24'h0; wdata4 = 12'h0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        step();
        check_eq("rst_valid8", valid8, 1'b0);
        check_eq("rst_rgb8",   rgb8,   24'h0);
        check_eq("rst_phase8", phase8, 1'b0);
        reset = 1'b0;

        // Foreground then background, blink mode.
        drive(1'b1, 8'h1E, 1'b1, 1'b1); step();
        drive(1'b1, 8'h1E, 1'b0, 1'b1); step();
        check_eq("fg_yellow", rgb8, 24'hFFFF55);
        check_eq("fg_valid",  valid8, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1); step();
        check_eq("bg_blue",   rgb8, 24'h0000AA);
        step();
        check_eq("valid_drop", valid8, 1'b0);

        // Bright background versus blink-mode background.
        drive(1'b1, 8'hC2, 1'b0, 1'b0); step();
        drive(1'b1, 8'hC2, 1'b0, 1'b1); step();
        check_eq("bright_bg", rgb8, 24'hFF5555);
        drive(1'b1, 8'h09, 1'b1, 1'b0); step();
        check_eq("blink_bg",  rgb8, 24'hAA0000);
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();
        check_eq("ch4_55f",   rgb4, 12'h55F);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("ch4_idle_v", valid4, 1'b0);
            check_eq("ch4_idle_c", rgb4,   12'h000);
        end

        // Blink timing with BLINK_FRAMES=2 on dut8.
        do_reset();
        drive(1'b1, 8'h8F, 1'b1, 1'b1);
        for (int p = 0; p < 3; p++) begin
            frame_start = 1'b1; step();
            frame_start = 1'b0; step();
            frame_start = 1'b1; step();
            check_eq("blink_toggle", phase8, (p % 2 == 0) ? 1'b1 : 1'b0);
            frame_start = 1'b0; step();
            check_eq("old_phase_px", rgb8, (p % 2 == 0) ? 24'hFFFFFF : 24'h000000);
            step();
            check_eq("new_phase_px", rgb8, (p % 2 == 0) ? 24'h000000 : 24'hFFFFFF);
        end

        // Palette write during streaming: read-before-write on the write edge.
        drive(1'b1, 8'h03, 1'b1, 1'b0); step();
        pal_we = 1'b1; pal_addr = 4'h3; wdata8 = 24'h123456; wdata4 = 12'h123;
        step();
        check_eq("wr_old", rgb8, 24'h00AAAA);
        pal_we = 1'b0; step();
        check_eq("wr_new", rgb8, 24'h123456);
        step();
        check_eq("wr_new2", rgb8, 24'h123456);
        drive(1'b1, 8'h05, 1'b1, 1'b0); step(); step();
        check_eq("wr_other", rgb8, 24'hAA00AA);

        // Reset restores defaults; pal_we during reset ignored.
        pal_we = 1'b1; pal_addr = 4'h0; wdata8 = 24'hFFFFFF; wdata4 = 12'hFFF;
        step();
        reset = 1'b1; step();
        reset = 1'b0; pal_we = 1'b0;
        check_eq("post_rst_v", valid8, 1'b0);
        check_eq("post_rst_p", phase8, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0); step();
        check_eq("flush_v", valid8, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();
        check_eq("rst_pal_v", valid8, 1'b1);
        check_eq("rst_pal_c", rgb8, 24'h000000);

        // Randomized traffic checked by the model each cycle.
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            pix_valid_in = ($urandom_range(0, 3) != 0);
            attribute    = 8'($urandom);
            glyph_pixel  = 1'($urandom);
            blink_mode   = 1'($urandom);
            frame_start  = ($urandom_range(0, 3) == 0);
            pal_we       = ($urandom_range(0, 7) == 0);
            pal_addr     = 4'($urandom);
            wdata8       = 24'($urandom);
            wdata4       = 12'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
